bus_arbiter: RTL and testbench

BUS_ARBITER -- requirements
Module: bus_arbiter

---
 rtl/bus_arbiter.sv | 152 +++++++++++++++
 tb/tb_bus_arbiter.sv | 408 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_arbiter.sv
// Two-port (CPU/host) arbiter in front of a single-ported memory.
// Round-robin or host-priority arbitration, fixed-length accesses.
module bus_arbiter #(
  parameter int HOST_PRIO  = 0,
  parameter int ACCESS_CYC = 1
) (
  input  logic        clk,
  input  logic        rstT,
  input  logic        c_req,
  input  logic        c_we,
  input  logic [11:0] c_addr,
  input  logic [15:0] c_wdata,
  output logic        c_gnt,
  output logic        c_ack,
  output logic [15:0] c_rdata,
  input  logic        h_req,
  input  logic        h_we,
  input  logic [11:0] h_addr,
  input  logic [15:0] h_wdata,
  output logic        h_gnt,
  output logic        h_ack,
  output logic [15:0] h_rdata,
  output logic        mem_en,
  output logic        mem_rdwr,
  output logic [11:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  output logic        busy,
  output logic        owner
);

  localparam int I_IDLE = 0;
  localparam int I_ACC  = 1;
  localparam int I_DONE = 2;

  localparam logic [2:0] S_IDLE   = 3'b001;
  localparam logic [2:0] S_ACCESS = 3'b010;
  localparam logic [2:0] S_DONE   = 3'b100;

  localparam logic [1:0] LAST_CNT = 2'(ACCESS_CYC - 1);

  logic [2:0]  state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic        owner_q, owner_d;
  logic        last_q, last_d;
  logic        we_q, we_d;
  logic [11:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic [15:0] c_rdata_q, c_rdata_d;
  logic [15:0] h_rdata_q, h_rdata_d;
  logic        host_win;
  logic        in_acc;
  logic        in_done;

  // last_q holds the previous winner; a tie goes to the other port
  always_comb begin
    host_win = h_req;
    if (HOST_PRIO == 0 && c_req && h_req) begin
      host_win = ~last_q;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    owner_d   = owner_q;
    last_d    = last_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    c_rdata_d = c_rdata_q;
    h_rdata_d = h_rdata_q;
    unique case (1'b1)
      state_q[I_IDLE]: begin
        if (c_req || h_req) begin
          owner_d = host_win;
          we_d    = host_win ? h_we : c_we;
          addr_d  = host_win ? h_addr : c_addr;
          wdata_d = host_win ? h_wdata : c_wdata;
          cnt_d   = 2'd0;
          state_d = S_ACCESS;
        end
      end
      state_q[I_ACC]: begin
        if (cnt_q == LAST_CNT) begin
          if (!we_q) begin
            if (owner_q) begin
              h_rdata_d = mem_rdata;
            end else begin
              c_rdata_d = mem_rdata;
            end
          end
          cnt_d   = 2'd0;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      state_q[I_DONE]: begin
        last_d  = owner_q;
        state_d = S_IDLE;
      end
      default: begin
        cnt_d   = 2'd0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rstT) begin
    if (rstT) begin
      state_q   <= S_IDLE;
      cnt_q     <= 2'd0;
      owner_q   <= 1'b0;
      last_q    <= 1'b1;
      we_q      <= 1'b0;
      addr_q    <= 12'd0;
      wdata_q   <= 16'd0;
      c_rdata_q <= 16'd0;
      h_rdata_q <= 16'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      owner_q   <= owner_d;
      last_q    <= last_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      c_rdata_q <= c_rdata_d;
      h_rdata_q <= h_rdata_d;
    end
  end

  assign in_acc  = state_q[I_ACC];
  assign in_done = state_q[I_DONE];

  // Memory bus is forced to zero outside ACCESS and wdata on reads
  assign mem_en    = in_acc;
  assign mem_rdwr  = in_acc & we_q;
  assign mem_addr  = in_acc ? addr_q : 12'd0;
  assign mem_wdata = (in_acc & we_q) ? wdata_q : 16'd0;

  assign c_gnt   = (in_acc | in_done) & ~owner_q;
  assign h_gnt   = (in_acc | in_done) & owner_q;
  assign c_ack   = in_done & ~owner_q;
  assign h_ack   = in_done & owner_q;
  assign c_rdata = c_rdata_q;
  assign h_rdata = h_rdata_q;
  assign busy    = ~state_q[I_IDLE];
  assign owner   = owner_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: three parameterisations on shared stimulus,
// a vector table, directed corner sequences and random traffic.
module tb_bus_arbiter;

  typedef struct packed {
    logic        mem_en;
    logic        mem_rdwr;
    logic [11:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        c_gnt;
    logic        h_gnt;
    logic        c_ack;
    logic        h_ack;
    logic [15:0] c_rdata;
    logic [15:0] h_rdata;
    logic        busy;
    logic        owner;
  } out_t;

  typedef struct {
    logic        c_req;
    logic        c_we;
    logic [11:0] c_addr;
    logic [15:0] c_wdata;
    logic        h_req;
    logic        h_we;
    logic [11:0] h_addr;
    logic [15:0] h_wdata;
    logic [15:0] mem_rdata;
    out_t        exp;
  } vec_t;

  logic        clk;
  logic        rstT;
  logic        c_req, c_we, h_req, h_we;
  logic [11:0] c_addr, h_addr;
  logic [15:0] c_wdata, h_wdata, mem_rdata;

  logic        c_gnt_w [3];
  logic        c_ack_w [3];
  logic [15:0] c_rdata_w [3];
  logic        h_gnt_w [3];
  logic        h_ack_w [3];
  logic [15:0] h_rdata_w [3];
  logic        mem_en_w [3];
  logic        mem_rdwr_w [3];
  logic [11:0] mem_addr_w [3];
  logic [15:0] mem_wdata_w [3];
  logic        busy_w [3];
  logic        owner_w [3];

  int errors = 0;
  int checks = 0;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    bus_arbiter #(
      .HOST_PRIO (g == 2 ? 1 : 0),
      .ACCESS_CYC(g == 0 ? 1 : (g == 1 ? 3 : 2))
    ) u_dut (
      .clk      (clk),
      .rstT     (rstT),
      .c_req    (c_req),
      .c_we     (c_we),
      .c_addr   (c_addr),
      .c_wdata  (c_wdata),
      .c_gnt    (c_gnt_w[g]),
      .c_ack    (c_ack_w[g]),
      .c_rdata  (c_rdata_w[g]),
      .h_req    (h_req),
      .h_we     (h_we),
      .h_addr   (h_addr),
      .h_wdata  (h_wdata),
      .h_gnt    (h_gnt_w[g]),
      .h_ack    (h_ack_w[g]),
      .h_rdata  (h_rdata_w[g]),
      .mem_en   (mem_en_w[g]),
      .mem_rdwr (mem_rdwr_w[g]),
      .mem_addr (mem_addr_w[g]),
      .mem_wdata(mem_wdata_w[g]),
      .mem_rdata(mem_rdata),
      .busy     (busy_w[g]),
      .owner    (owner_w[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int cyc_of(int m);
    return (m == 0) ? 1 : ((m == 1) ? 3 : 2);
  endfunction

  function automatic int prio_of(int m);
    return (m == 2) ? 1 : 0;
  endfunction

  // Reference model: mt = cycles since grant (0 idle, 1..N access, N+1 done)
  int          mt [3];
  logic        mown [3];
  logic        mlast [3];
  logic        mwe [3];
  logic [11:0] maddr [3];
  logic [15:0] mwd [3];
  logic [15:0] mcrd [3];
  logic [15:0] mhrd [3];

  function automatic void model_reset();
    for (int m = 0; m < 3; m++) begin
      mt[m] = 0; mown[m] = 1'b0; mlast[m] = 1'b1; mwe[m] = 1'b0;
      maddr[m] = '0; mwd[m] = '0; mcrd[m] = '0; mhrd[m] = '0;
    end
  endfunction

  function automatic void model_edge(int m);
    logic win;
    int   cyc;
    cyc = cyc_of(m);
    if (mt[m] == 0) begin
      if (c_req || h_req) begin
        if (prio_of(m) != 0) win = h_req;
        else if (c_req && h_req) win = !mlast[m];
        else win = h_req;
        mown[m] = win;
        mwe[m] = win ? h_we : c_we;
        maddr[m] = win ? h_addr : c_addr;
        mwd[m] = win ? h_wdata : c_wdata;
        mt[m] = 1;
      end
    end else if (mt[m] <= cyc) begin
      if (mt[m] == cyc && !mwe[m]) begin
        if (mown[m]) mhrd[m] = mem_rdata;
        else mcrd[m] = mem_rdata;
      end
      mt[m] = mt[m] + 1;
    end else begin
      mlast[m] = mown[m];
      mt[m] = 0;
    end
  endfunction

  function automatic out_t exp_of(int m);
    out_t e;
    logic acc, dn;
    acc = (mt[m] >= 1) && (mt[m] <= cyc_of(m));
    dn = (mt[m] == cyc_of(m) + 1);
    e.mem_en = acc;
    e.mem_rdwr = acc && mwe[m];
    e.mem_addr = acc ? maddr[m] : 12'd0;
    e.mem_wdata = (acc && mwe[m]) ? mwd[m] : 16'd0;
    e.c_gnt = (acc || dn) && !mown[m];
    e.h_gnt = (acc || dn) && mown[m];
    e.c_ack = dn && !mown[m];
    e.h_ack = dn && mown[m];
    e.c_rdata = mcrd[m];
    e.h_rdata = mhrd[m];
    e.busy = (mt[m] != 0);
    e.owner = mown[m];
    return e;
  endfunction

  function automatic out_t act_of(int m);
    out_t a;
    a.mem_en = mem_en_w[m];
    a.mem_rdwr = mem_rdwr_w[m];
    a.mem_addr = mem_addr_w[m];
    a.mem_wdata = mem_wdata_w[m];
    a.c_gnt = c_gnt_w[m];
    a.h_gnt = h_gnt_w[m];
    a.c_ack = c_ack_w[m];
    a.h_ack = h_ack_w[m];
    a.c_rdata = c_rdata_w[m];
    a.h_rdata = h_rdata_w[m];
    a.busy = busy_w[m];
    a.owner = owner_w[m];
    return a;
  endfunction

  function automatic out_t eo(
    logic en, logic rw, logic [11:0] ad, logic [15:0] wd,
    logic cg, logic hg, logic ca, logic ha,
    logic [15:0] crd, logic [15:0] hrd, logic bz, logic ow);
    out_t e;
    e = '{en, rw, ad, wd, cg, hg, ca, ha, crd, hrd, bz, ow};
    return e;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic check_all();
    out_t a, e;
    for (int m = 0; m < 3; m++) begin
      a = act_of(m);
      e = exp_of(m);
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL model inst%0d at %0t: got %h expected %h", m, $time, a, e);
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    if (rstT) model_reset();
    else for (int m = 0; m < 3; m++) model_edge(m);
    #1;
    check_all();
  endtask

  task automatic idle_inputs();
    c_req = 0; c_we = 0; c_addr = '0; c_wdata = '0;
    h_req = 0; h_we = 0; h_addr = '0; h_wdata = '0;
    mem_rdata = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rstT = 1'b1;
    #1;
    model_reset();
    check_all();
    @(posedge clk);
    #1;
    check_all();
    rstT = 1'b0;
  endtask

  task automatic pulse_reset();
    rstT = 1'b1;
    #1;
    model_reset();
    check_all();
    #1;
    rstT = 1'b0;
  endtask

  vec_t tbl [12];
  int   en0, en1, ack0, ack1, bad, cg, seen;

  initial begin
    tbl[0]  = '{1, 0, 12'h123, 16'h0, 0, 0, 12'h0, 16'h0, 16'h0,
                eo(1, 0, 12'h123, 16'h0, 1, 0, 0, 0, 16'h0, 16'h0, 1, 0)};
    tbl[1]  = '{1, 0, 12'h123, 16'h0, 0, 0, 12'h0, 16'h0, 16'hBEEF,
                eo(0, 0, 12'h0, 16'h0, 1, 0, 1, 0, 16'hBEEF, 16'h0, 1, 0)};
    tbl[2]  = '{0, 0, 12'h0, 16'h0, 0, 0, 12'h0, 16'h0, 16'h0,
                eo(0, 0, 12'h0, 16'h0, 0, 0, 0, 0, 16'hBEEF, 16'h0, 0, 0)};
    tbl[3]  = '{1, 1, 12'h0AA, 16'h1111, 1, 0, 12'h0BB, 16'h0, 16'h0,
                eo(1, 0, 12'h0BB, 16'h0, 0, 1, 0, 0, 16'hBEEF, 16'h0, 1, 1)};
    tbl[4]  = '{1, 1, 12'h0AA, 16'h1111, 1, 0, 12'h0BB, 16'h0, 16'h2222,
                eo(0, 0, 12'h0, 16'h0, 0, 1, 0, 1, 16'hBEEF, 16'h2222, 1, 1)};
    tbl[5]  = '{1, 1, 12'h0AA, 16'h1111, 1, 0, 12'h0BB, 16'h0, 16'h0,
                eo(0, 0, 12'h0, 16'h0, 0, 0, 0, 0, 16'hBEEF, 16'h2222, 0, 1)};
    tbl[6]  = '{1, 1, 12'h0AA, 16'h1111, 1, 0, 12'h0BB, 16'h0, 16'h0,
                eo(1, 1, 12'h0AA, 16'h1111, 1, 0, 0, 0, 16'hBEEF, 16'h2222, 1, 0)};
    tbl[7]  = '{1, 1, 12'h0AA, 16'h1111, 1, 0, 12'h0BB, 16'h0, 16'h3333,
                eo(0, 0, 12'h0, 16'h0, 1, 0, 1, 0, 16'hBEEF, 16'h2222, 1, 0)};
    tbl[8]  = '{1, 1, 12'h0AA, 16'h1111, 1, 0, 12'h0BB, 16'h0, 16'h0,
                eo(0, 0, 12'h0, 16'h0, 0, 0, 0, 0, 16'hBEEF, 16'h2222, 0, 0)};
    tbl[9]  = '{1, 1, 12'h0AA, 16'h1111, 1, 0, 12'h0BB, 16'h0, 16'h0,
                eo(1, 0, 12'h0BB, 16'h0, 0, 1, 0, 0, 16'hBEEF, 16'h2222, 1, 1)};
    tbl[10] = '{1, 1, 12'h0AA, 16'h1111, 1, 0, 12'h0BB, 16'h0, 16'h4444,
                eo(0, 0, 12'h0, 16'h0, 0, 1, 0, 1, 16'hBEEF, 16'h4444, 1, 1)};
    tbl[11] = '{0, 0, 12'h0, 16'h0, 0, 0, 12'h0, 16'h0, 16'h0,
                eo(0, 0, 12'h0, 16'h0, 0, 0, 0, 0, 16'hBEEF, 16'h4444, 0, 1)};

    do_reset();
    chk("reset_owner", {31'd0, owner_w[0]}, 32'd0);
    chk("reset_busy", {31'd0, busy_w[1]}, 32'd0);

    // CPU read then round-robin alternation on the single-cycle instance
    for (int i = 0; i < 12; i++) begin
      c_req = tbl[i].c_req; c_we = tbl[i].c_we;
      c_addr = tbl[i].c_addr; c_wdata = tbl[i].c_wdata;
      h_req = tbl[i].h_req; h_we = tbl[i].h_we;
      h_addr = tbl[i].h_addr; h_wdata = tbl[i].h_wdata;
      mem_rdata = tbl[i].mem_rdata;
      step();
      checks++;
      if (act_of(0) !== tbl[i].exp) begin
        errors++;
        $display("FAIL vec%0d: got %h expected %h", i, act_of(0), tbl[i].exp);
      end
    end

    // Host write, three-cycle access
    do_reset();
    h_req = 1; h_we = 1; h_addr = 12'hFFF; h_wdata = 16'hA5A5;
    en1 = 0; ack1 = 0; bad = 0;
    for (int k = 0; k < 12; k++) begin
      mem_rdata = 16'($urandom);
      step();
      if (mem_en_w[1]) begin
        en1++;
        if (!(mem_rdwr_w[1] && mem_wdata_w[1] == 16'hA5A5 && mem_addr_w[1] == 12'hFFF)) bad++;
      end
      if (h_ack_w[1]) begin
        ack1++;
        h_req = 0;
      end
    end
    chk("hwr_en_cycles", en1, 3);
    chk("hwr_bus_values", bad, 0);
    chk("hwr_ack_count", ack1, 1);
    chk("hwr_c_rdata", {16'd0, c_rdata_w[1]}, 32'd0);

    // Host priority: CPU starved while host keeps requesting
    do_reset();
    c_req = 1; c_addr = 12'h010; h_req = 1; h_addr = 12'h020;
    cg = 0; ack1 = 0;
    for (int k = 0; k < 20; k++) begin
      mem_rdata = 16'($urandom);
      step();
      if (c_gnt_w[2]) cg++;
      if (h_ack_w[2]) ack1++;
    end
    chk("prio_cpu_starved", cg, 0);
    chk("prio_host_acks", ack1, 5);
    h_req = 0;
    seen = 0;
    for (int k = 0; k < 8 && seen == 0; k++) begin
      step();
      if (c_gnt_w[2]) seen = 1;
    end
    chk("prio_cpu_after_drop", seen, 1);
    c_req = 0;
    for (int k = 0; k < 6; k++) step();

    // Reset on the 2nd access cycle aborts without an ack
    do_reset();
    c_req = 1; c_we = 0; c_addr = 12'h055;
    mem_rdata = 16'h7777;
    step();
    step();
    chk("abort_pre_en", {31'd0, mem_en_w[1]}, 32'd1);
    #2;
    pulse_reset();
    chk("abort_en_drop", {31'd0, mem_en_w[1]}, 32'd0);
    c_req = 0;
    ack1 = 0;
    for (int k = 0; k < 6; k++) begin
      step();
      if (c_ack_w[1]) ack1++;
    end
    chk("abort_no_ack", ack1, 0);
    c_req = 1; c_addr = 12'h077; mem_rdata = 16'h5A5A;
    seen = 0;
    for (int k = 0; k < 8 && seen == 0; k++) begin
      step();
      if (c_ack_w[1]) seen = 1;
    end
    chk("abort_next_ack", seen, 1);
    chk("abort_next_data", {16'd0, c_rdata_w[1]}, 32'h5A5A);
    c_req = 0;
    for (int k = 0; k < 6; k++) step();

    // Request withdrawn on the first access cycle
    do_reset();
    c_req = 1; c_we = 0; c_addr = 12'h321;
    step();
    en0 = mem_en_w[0] ? 1 : 0;
    en1 = mem_en_w[1] ? 1 : 0;
    ack0 = 0; ack1 = 0;
    c_req = 0;
    for (int k = 0; k < 8; k++) begin
      mem_rdata = 16'($urandom);
      step();
      if (mem_en_w[0]) en0++;
      if (mem_en_w[1]) en1++;
      if (c_ack_w[0]) ack0++;
      if (c_ack_w[1]) ack1++;
    end
    chk("drop_en_a", en0, 1);
    chk("drop_ack_a", ack0, 1);
    chk("drop_en_b", en1, 3);
    chk("drop_ack_b", ack1, 1);

    // Random traffic against the reference model
    do_reset();
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 149) == 0) pulse_reset();
      c_req = ($urandom_range(0, 2) != 0);
      c_we = 1'($urandom);
      c_addr = 12'($urandom);
      c_wdata = 16'($urandom);
      h_req = ($urandom_range(0, 2) != 0);
      h_we = 1'($urandom);
      h_addr = 12'($urandom);
      h_wdata = 16'($urandom);
      mem_rdata = 16'($urandom);
      step();
      if (c_gnt_w[i % 3] && h_gnt_w[i % 3]) begin
        errors++;
        $display("FAIL both_gnt inst%0d at %0t", i % 3, $time);
      end
      checks++;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
